enc4_2_sync: RTL and testbench
==============================

ENC4_2_SYNC -- requirements
Module: enc4_2_sync

Interface
REQ-001 Parameter PRIO_HIGH, default 1, 1 = highest set bit wins, 0 = lowest set bit wins.
REQ-002 Parameter ERR_W, default 8, width of error counter.
REQ-003 clk  input  1  rising-edge clock; the single clock.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  block enable; 0 freezes all state.
REQ-006 in_vld  input  1  d_in valid.
REQ-007 in_rdy  output  1  block accepts d_in this cycle.
REQ-008 d_in  input  4  request vector (one-hot expected).
REQ-009 out_vld  output  1  code_out valid.
REQ-010 out_rdy  input  1  downstream accepts code_out.
REQ-011 code_out  output  2  encoded index of selected bit.
REQ-012 multi_hot  output  1  qualifies code_out: source vector had >1 bit set.
REQ-013 err_cnt  output  ERR_W  count of rejected all-zero vectors, saturating.
REQ-014 err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-015 Input handshake SHALL complete on a rising edge with en=1, in_vld=1, in_rdy=1.
REQ-016 in_rdy SHALL be en AND (state==EMPTY OR out_rdy), combinational; full-throughput with one output register.
REQ-017 FSM SHALL have two states: EMPTY (out_vld=0) and FULL (out_vld=1).
REQ-018 EMPTY->FULL on accepted non-zero d_in; EMPTY stays EMPTY on accepted all-zero d_in.
REQ-019 FULL->EMPTY on out_rdy=1 with no accepted non-zero d_in in the same cycle; FULL stays FULL on out_rdy=1 plus accepted non-zero d_in (code_out replaced, no bubble).
REQ-020 FULL with out_rdy=0 SHALL hold code_out and multi_hot stable.
REQ-021 Latency SHALL be exactly 1 cycle: accepted d_in at edge N appears on code_out/out_vld after edge N.
REQ-022 Encoding for one-hot d_in: 0001->00, 0010->01, 0100->10, 1000->11.
REQ-023 Multi-hot d_in SHALL encode index of highest set bit when PRIO_HIGH=1, lowest when PRIO_HIGH=0, and set multi_hot=1; else multi_hot=0.
REQ-024 Accepted all-zero d_in SHALL produce no output, leave code_out/multi_hot unchanged, and increment err_cnt by 1.
REQ-025 err_cnt SHALL saturate at all-ones; no wrap.
REQ-026 err_clr=1 SHALL set err_cnt to 0 on next edge and takes priority over a simultaneous increment.
REQ-027 en=0 SHALL hold FSM state, code_out, multi_hot, out_vld; out_rdy is ignored (no FULL->EMPTY); err_clr still acts.
REQ-028 d_in SHALL be ignored when no handshake occurs; no X propagation from unaccepted d_in.

Reset
REQ-029 rst_n=0 SHALL immediately force state=EMPTY, out_vld=0, code_out=00, multi_hot=0, err_cnt=0, independent of clk.
REQ-030 Reset asserted while FULL SHALL discard the pending code; no output after release until a new accepted vector.
REQ-031 in_rdy SHALL be 0 while rst_n=0.
REQ-032 Reset release SHALL be usable on any edge; first handshake possible on the first edge after deassertion.

Verification
REQ-033 Reset, en=1, out_rdy=1, stream d_in 0001,0010,0100,1000 back-to-back -> code_out 00,01,10,11 on consecutive cycles, out_vld=1 throughout, multi_hot=0.
REQ-034 PRIO_HIGH=1, d_in=0110 -> code_out=10, multi_hot=1; PRIO_HIGH=0, same -> code_out=01, multi_hot=1.
REQ-035 d_in=0100 accepted, out_rdy=0 for 3 cycles, in_vld=1 d_in=0001 -> in_rdy=0, code_out held at 10; out_rdy=1 -> 0001 accepted, code_out=00 next cycle.
REQ-036 ERR_W=2, send 5 all-zero vectors -> err_cnt 1,2,3,3,3, out_vld stays 0; err_clr with simultaneous zero vector -> err_cnt=0.
REQ-037 FULL with code_out=11, assert rst_n=0 mid-cycle -> out_vld=0, code_out=00 immediately; after release, out_vld stays 0 until new input.
REQ-038 FULL, en=0, out_rdy=1 for 2 cycles -> out_vld stays 1, in_rdy=0; en=1 -> transfer completes, out_vld=0 next cycle.

Source files
------------

// File: rtl/enc4_2_sync.sv
// Registered 4:2 priority encoder with a valid/ready handshake and a saturating
// counter of rejected all-zero request vectors.
module enc4_2_sync #(
  parameter int PRIO_HIGH = 1,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [3:0]       d_in,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [1:0]       code_out,
  output logic             multi_hot,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [1:0] code;
    logic       multi;
  } enc_rsp_t;

  state_t   state;
  enc_rsp_t enc;
  logic     accept;
  logic     nz;

  // Reset is folded in so the upstream never sees a ready while held in reset.
  assign in_rdy = rst_n & en & ((state == EMPTY) | out_rdy);
  assign accept = in_vld & in_rdy;
  assign nz     = |d_in;

  always_comb begin
    enc.multi = (d_in[0] & d_in[1]) | (d_in[0] & d_in[2]) | (d_in[0] & d_in[3]) |
                (d_in[1] & d_in[2]) | (d_in[1] & d_in[3]) | (d_in[2] & d_in[3]);
    enc.code  = 2'b00;
    if (PRIO_HIGH != 0) begin
      if      (d_in[3]) enc.code = 2'b11;
      else if (d_in[2]) enc.code = 2'b10;
      else if (d_in[1]) enc.code = 2'b01;
      else              enc.code = 2'b00;
    end else begin
      if      (d_in[0]) enc.code = 2'b00;
      else if (d_in[1]) enc.code = 2'b01;
      else if (d_in[2]) enc.code = 2'b10;
      else              enc.code = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_vld   <= 1'b0;
      code_out  <= 2'b00;
      multi_hot <= 1'b0;
    end else if (en) begin
      // A new non-zero vector replaces the held code even while draining.
      if (accept && nz) begin
        state     <= FULL;
        out_vld   <= 1'b1;
        code_out  <= enc.code;
        multi_hot <= enc.multi;
      end else if (state == FULL && out_rdy) begin
        state   <= EMPTY;
        out_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (accept && !nz && (err_cnt != {ERR_W{1'b1}}))
      err_cnt <= err_cnt + ERR_W'(1);
  end

endmodule

// File: tb/tb_enc4_2_sync.sv
// Directed bench: a default instance (high priority, 8-bit counter) and a
// low-priority instance with a 2-bit counter share one stimulus stream.
module tb_enc4_2_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_vld;
  logic [3:0] d_in;
  logic       out_rdy;
  logic       err_clr;

  logic       in_rdy_h, out_vld_h, mh_h;
  logic [1:0] code_h;
  logic [7:0] err_h;
  logic       in_rdy_l, out_vld_l, mh_l;
  logic [1:0] code_l;
  logic [1:0] err_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enc4_2_sync #(.PRIO_HIGH(1), .ERR_W(8)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .in_rdy(in_rdy_h),
    .d_in(d_in), .out_vld(out_vld_h), .out_rdy(out_rdy), .code_out(code_h),
    .multi_hot(mh_h), .err_cnt(err_h), .err_clr(err_clr)
  );

  enc4_2_sync #(.PRIO_HIGH(0), .ERR_W(2)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .in_rdy(in_rdy_l),
    .d_in(d_in), .out_vld(out_vld_l), .out_rdy(out_rdy), .code_out(code_l),
    .multi_hot(mh_l), .err_cnt(err_l), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the high-priority instance's output register.
  task automatic chk_h(input string tag, input logic v, input logic [1:0] c, input logic m);
    chk({tag, ".h.vld"}, {7'd0, out_vld_h}, {7'd0, v});
    chk({tag, ".h.code"}, {6'd0, code_h}, {6'd0, c});
    chk({tag, ".h.mh"}, {7'd0, mh_h}, {7'd0, m});
  endtask

  task automatic chk_l(input string tag, input logic v, input logic [1:0] c, input logic m);
    chk({tag, ".l.vld"}, {7'd0, out_vld_l}, {7'd0, v});
    chk({tag, ".l.code"}, {6'd0, code_l}, {6'd0, c});
    chk({tag, ".l.mh"}, {7'd0, mh_l}, {7'd0, m});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_vld = 1'b1; d_in = 4'b0001; out_rdy = 1'b1; err_clr = 1'b0;
    #1;
    chk("rst.in_rdy.h", {7'd0, in_rdy_h}, 8'd0);
    chk("rst.in_rdy.l", {7'd0, in_rdy_l}, 8'd0);
    tick(); tick();
    chk_h("rst", 1'b0, 2'b00, 1'b0);
    chk_l("rst", 1'b0, 2'b00, 1'b0);
    chk("rst.err.h", err_h, 8'd0);
    chk("rst.err.l", {6'd0, err_l}, 8'd0);

    // Back-to-back one-hot stream, first handshake on the first edge after release.
    rst_n = 1'b1;
    #1;
    chk("stream.in_rdy", {7'd0, in_rdy_h}, 8'd1);
    tick(); chk_h("s0001", 1'b1, 2'b00, 1'b0); chk_l("s0001", 1'b1, 2'b00, 1'b0);
    d_in = 4'b0010;
    tick(); chk_h("s0010", 1'b1, 2'b01, 1'b0); chk_l("s0010", 1'b1, 2'b01, 1'b0);
    d_in = 4'b0100;
    tick(); chk_h("s0100", 1'b1, 2'b10, 1'b0); chk_l("s0100", 1'b1, 2'b10, 1'b0);
    d_in = 4'b1000;
    tick(); chk_h("s1000", 1'b1, 2'b11, 1'b0); chk_l("s1000", 1'b1, 2'b11, 1'b0);

    // Multi-hot priority in both directions.
    d_in = 4'b0110;
    tick(); chk_h("m0110", 1'b1, 2'b10, 1'b1); chk_l("m0110", 1'b1, 2'b01, 1'b1);
    d_in = 4'b1011;
    tick(); chk_h("m1011", 1'b1, 2'b11, 1'b1); chk_l("m1011", 1'b1, 2'b00, 1'b1);
    in_vld = 1'b0; d_in = 4'bxxxx;
    tick(); chk_h("drain", 1'b0, 2'b11, 1'b1);

    // Backpressure hold.
    in_vld = 1'b1; d_in = 4'b0100; out_rdy = 1'b0;
    tick(); chk_h("bp.load", 1'b1, 2'b10, 1'b0);
    d_in = 4'b0001;
    #1;
    chk("bp.in_rdy", {7'd0, in_rdy_h}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_h("bp.hold", 1'b1, 2'b10, 1'b0);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp.in_rdy1", {7'd0, in_rdy_h}, 8'd1);
    tick(); chk_h("bp.next", 1'b1, 2'b00, 1'b0);
    d_in = 4'b1000;
    tick(); chk_h("pre.err", 1'b1, 2'b11, 1'b0);
    in_vld = 1'b0;
    tick(); chk_h("pre.err.empty", 1'b0, 2'b11, 1'b0);

    // All-zero vectors: no output, counters saturate independently.
    in_vld = 1'b1; d_in = 4'b0000;
    tick(); chk("z1.l", {6'd0, err_l}, 8'd1); chk("z1.h", err_h, 8'd1);
    tick(); chk("z2.l", {6'd0, err_l}, 8'd2);
    tick(); chk("z3.l", {6'd0, err_l}, 8'd3);
    tick(); chk("z4.l", {6'd0, err_l}, 8'd3);
    tick(); chk("z5.l", {6'd0, err_l}, 8'd3); chk("z5.h", err_h, 8'd5);
    chk_h("zero.noout", 1'b0, 2'b11, 1'b0);
    err_clr = 1'b1;
    tick(); chk("clr.l", {6'd0, err_l}, 8'd0); chk("clr.h", err_h, 8'd0);
    err_clr = 1'b0; in_vld = 1'b0;

    // Asynchronous reset while FULL.
    in_vld = 1'b1; d_in = 4'b1000;
    tick(); chk_h("ar.full", 1'b1, 2'b11, 1'b0);
    in_vld = 1'b0; out_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_h("ar.now", 1'b0, 2'b00, 1'b0);
    chk("ar.in_rdy", {7'd0, in_rdy_h}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    chk_h("ar.after", 1'b0, 2'b00, 1'b0);

    // Enable low freezes a full register despite out_rdy; zeros not counted.
    out_rdy = 1'b1; in_vld = 1'b1; d_in = 4'b0100;
    tick(); chk_h("en.load", 1'b1, 2'b10, 1'b0);
    en = 1'b0; d_in = 4'b0000;
    #1;
    chk("en.in_rdy", {7'd0, in_rdy_h}, 8'd0);
    tick(); chk_h("en.hold1", 1'b1, 2'b10, 1'b0);
    tick(); chk_h("en.hold2", 1'b1, 2'b10, 1'b0);
    chk("en.err", err_h, 8'd0);
    en = 1'b1; in_vld = 1'b0;
    tick(); chk_h("en.drain", 1'b0, 2'b10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
